// File: rtl/mem_responder.sv
// mem_responder: single-clock word memory that answers an instruction-fetch
// port (registered, 1-cycle latency) and a data port (combinational load,
// clocked store). It keeps a sticky access-error flag and per-class access
// counters.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   imemreq_val/addr         fetch request
//   imemresp_val/data        fetch response, one cycle after the request edge
//   dmemreq_val/type/addr/wdata  data request (type 0 = read, 1 = write)
//   dmemresp_data            load data, same cycle; 0 unless a legal read
//   err                      sticky: set by any valid request to an illegal address
//   cnt_ifetch/load/store    free-running 32-bit access counters
//
// The storage array `mem` is deliberately not reset. The bench preloads it
// through hierarchical access.

// Address decoder for one request port: legal means word-aligned and inside
// [BASE, BASE + 4*WORDS).
module mem_addr_dec #(
  parameter int          WORDS = 256,
  parameter logic [31:0] BASE  = 32'h0000_0000,
  parameter int          AW    = 8
) (
  input  logic [31:0]   addr,
  output logic          legal,
  output logic [AW-1:0] idx
);
  // A 33-bit difference lets the borrow bit flag addresses below BASE.
  logic [32:0] off;
  assign off   = {1'b0, addr} - {1'b0, BASE};
  assign legal = (addr[1:0] == 2'b00) && !off[32] && (off[31:0] < 32'(4 * WORDS));
  assign idx   = off[AW+1:2];
endmodule

module mem_responder #(
  parameter int          WORDS = 256,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imemreq_val,
  input  logic [31:0] imemreq_addr,
  output logic        imemresp_val,
  output logic [31:0] imemresp_data,
  input  logic        dmemreq_val,
  input  logic        dmemreq_type,
  input  logic [31:0] dmemreq_addr,
  input  logic [31:0] dmemreq_wdata,
  output logic [31:0] dmemresp_data,
  output logic        err,
  output logic [31:0] cnt_ifetch,
  output logic [31:0] cnt_load,
  output logic [31:0] cnt_store
);
  localparam int AW = $clog2(WORDS);

  logic [31:0] mem [WORDS];

  // Port 0 = fetch, port 1 = data.
  logic [1:0][31:0]   addr;
  logic [1:0]         legal;
  logic [1:0][AW-1:0] idx;

  assign addr[0] = imemreq_addr;
  assign addr[1] = dmemreq_addr;

  for (genvar p = 0; p < 2; p++) begin : g_dec
    mem_addr_dec #(.WORDS(WORDS), .BASE(BASE), .AW(AW)) u_dec (
      .addr  (addr[p]),
      .legal (legal[p]),
      .idx   (idx[p])
    );
  end

  logic ld, st;
  assign ld = dmemreq_val && !dmemreq_type;
  assign st = dmemreq_val &&  dmemreq_type;

  // Load path is purely combinational.
  assign dmemresp_data = (ld && legal[1]) ? mem[idx[1]] : 32'h0;

  // Storage: no reset. The fetch register samples mem with the same edge that
  // commits a store, so a colliding fetch sees the old word.
  always_ff @(posedge clk) begin
    if (st && legal[1]) mem[idx[1]] <= dmemreq_wdata;
  end

  // Fetch response register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imemresp_val  <= 1'b0;
      imemresp_data <= 32'h0;
    end else begin
      imemresp_val <= imemreq_val;
      if (imemreq_val) imemresp_data <= legal[0] ? mem[idx[0]] : 32'h0;
    end
  end

  // Sticky error and counters. Counters count requests regardless of
  // legality and wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err        <= 1'b0;
      cnt_ifetch <= 32'h0;
      cnt_load   <= 32'h0;
      cnt_store  <= 32'h0;
    end else begin
      if ((imemreq_val && !legal[0]) || (dmemreq_val && !legal[1])) err <= 1'b1;
      if (imemreq_val) cnt_ifetch <= cnt_ifetch + 32'd1;
      if (ld)          cnt_load   <= cnt_load   + 32'd1;
      if (st)          cnt_store  <= cnt_store  + 32'd1;
    end
  end
endmodule
